// File: rtl/pool_pkg.sv
// Shared constants and the ordering-key helper for the streaming max pooler.
package pool_pkg;

  localparam int unsigned MODE_INT     = 0;
  localparam int unsigned MODE_FP      = 1;
  localparam int unsigned KEY_MAX_BITS = 64;

  // Maps a value to an unsigned key whose order matches signed-int or IEEE-754 order.
  // The caller keeps the low msb+1 bits of the result.
  function automatic logic [KEY_MAX_BITS-1:0] pool_key(
    input logic [KEY_MAX_BITS-1:0] x,
    input int unsigned             msb,
    input logic                    fp_mode
  );
    logic [KEY_MAX_BITS-1:0] sign_bit;
    sign_bit = KEY_MAX_BITS'(1) << msb;
    if (fp_mode && ((x & sign_bit) != '0)) pool_key = ~x;
    else                                   pool_key = x ^ sign_bit;
  endfunction

endpackage

// File: rtl/pool_cmp_max.sv
// Combinational two-input maximum of one channel value, signed-int or IEEE-754 ordering.
module pool_cmp_max
  import pool_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned MODE      = MODE_FP
) (
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  output logic [DATA_BITS-1:0] max_c
);

  if (DATA_BITS > KEY_MAX_BITS) begin : g_bad_bits
    $error("pool_cmp_max: DATA_BITS exceeds KEY_MAX_BITS");
  end

  logic [DATA_BITS-1:0] key_a;
  logic [DATA_BITS-1:0] key_b;

  assign key_a = DATA_BITS'(pool_key(KEY_MAX_BITS'(a), DATA_BITS - 1, MODE == MODE_FP));
  assign key_b = DATA_BITS'(pool_key(KEY_MAX_BITS'(b), DATA_BITS - 1, MODE == MODE_FP));
  assign max_c = (key_b > key_a) ? b : a;

endmodule

// File: rtl/max_pooling_stream.sv
// Streaming KxK stride-K max pooling over a raster-order frame, one pixel per beat,
// with a single (W/K)-entry row buffer holding partial vertical maxima.
module max_pooling_stream
  import pool_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned D         = 1,
  parameter int unsigned W         = 48,
  parameter int unsigned H         = 48,
  parameter int unsigned K         = 2,
  parameter int unsigned MODE      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [D*DATA_BITS-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D*DATA_BITS-1:0] out_data,
  output logic                   frame_done
);

  localparam int unsigned PIX_BITS = D * DATA_BITS;
  localparam int unsigned NWIN_X   = W / K;
  localparam int unsigned NWIN_Y   = H / K;
  localparam int unsigned KW_BITS  = $clog2(K);
  localparam int unsigned JX_BITS  = (NWIN_X > 1) ? $clog2(NWIN_X) : 1;
  localparam int unsigned JY_BITS  = (NWIN_Y > 1) ? $clog2(NWIN_Y) : 1;

  if (K < 2)      begin : g_bad_k $error("max_pooling_stream: K must be >= 2"); end
  if (W % K != 0) begin : g_bad_w $error("max_pooling_stream: W must be a multiple of K"); end
  if (H % K != 0) begin : g_bad_h $error("max_pooling_stream: H must be a multiple of K"); end

  // col/row are held split as (window index, offset within window) to avoid dividers.
  logic [KW_BITS-1:0]  kc_q, kc_d, kr_q, kr_d;
  logic [JX_BITS-1:0]  jx_q, jx_d;
  logic [JY_BITS-1:0]  jy_q, jy_d;
  logic [PIX_BITS-1:0] h_acc_q, h_acc_d;
  logic [PIX_BITS-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                frame_done_q, frame_done_d;

  logic [PIX_BITS-1:0] rowbuf_q [NWIN_X];
  logic [PIX_BITS-1:0] rb_rdata;
  logic [PIX_BITS-1:0] rb_wdata;
  logic                rb_we;
  logic [PIX_BITS-1:0] h_max_c;
  logic [PIX_BITS-1:0] win_max_c;
  logic                accept;
  logic                last_col;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign rb_rdata   = rowbuf_q[jx_q];

  for (genvar c = 0; c < D; c++) begin : g_ch
    pool_cmp_max #(.DATA_BITS(DATA_BITS), .MODE(MODE)) u_h_max (
      .a     (h_acc_q[c*DATA_BITS +: DATA_BITS]),
      .b     (in_data[c*DATA_BITS +: DATA_BITS]),
      .max_c (h_max_c[c*DATA_BITS +: DATA_BITS])
    );
    pool_cmp_max #(.DATA_BITS(DATA_BITS), .MODE(MODE)) u_v_max (
      .a     (rb_rdata[c*DATA_BITS +: DATA_BITS]),
      .b     (h_max_c[c*DATA_BITS +: DATA_BITS]),
      .max_c (win_max_c[c*DATA_BITS +: DATA_BITS])
    );
  end

  always_comb begin
    kc_d         = kc_q;
    kr_d         = kr_q;
    jx_d         = jx_q;
    jy_d         = jy_q;
    h_acc_d      = h_acc_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = out_valid_q && out_ready && out_last_q;
    rb_we        = 1'b0;
    rb_wdata     = h_max_c;
    last_col     = (jx_q == JX_BITS'(NWIN_X - 1));

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      h_acc_d = (kc_q == '0) ? in_data : h_max_c;
      if (kc_q != KW_BITS'(K - 1)) begin
        kc_d = kc_q + KW_BITS'(1);
      end else begin
        // Window column complete: seed, fold into, or drain the row buffer entry.
        kc_d = '0;
        jx_d = last_col ? '0 : jx_q + JX_BITS'(1);
        if (kr_q == '0) begin
          rb_we    = 1'b1;
          rb_wdata = h_max_c;
        end else if (kr_q != KW_BITS'(K - 1)) begin
          rb_we    = 1'b1;
          rb_wdata = win_max_c;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = win_max_c;
          out_last_d  = last_col && (jy_q == JY_BITS'(NWIN_Y - 1));
        end
        if (last_col) begin
          if (kr_q == KW_BITS'(K - 1)) begin
            kr_d = '0;
            jy_d = (jy_q == JY_BITS'(NWIN_Y - 1)) ? '0 : jy_q + JY_BITS'(1);
          end else begin
            kr_d = kr_q + KW_BITS'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kc_q         <= '0;
      kr_q         <= '0;
      jx_q         <= '0;
      jy_q         <= '0;
      h_acc_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      kc_q         <= kc_d;
      kr_q         <= kr_d;
      jx_q         <= jx_d;
      jy_q         <= jy_d;
      h_acc_q      <= h_acc_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffer has no reset so it maps onto a read-first single-port RAM.
  always_ff @(posedge clk) begin
    if (rb_we) rowbuf_q[jx_q] <= rb_wdata;
  end

endmodule
